// File: rtl/stream_demux_pkg.sv
// Shared types and defaults for the stream demultiplexer.
package stream_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam int unsigned DEF_WIDTH = 2;
  localparam int unsigned DEF_N_OUT = 4;
  localparam int unsigned DEF_SEL_W = 2;
  localparam int unsigned DEF_CNT_W = 8;

  // A select value addresses a real lane only when it is below the lane count.
  function automatic logic lane_ok(input int unsigned sel, input int unsigned n_out);
    return sel < n_out;
  endfunction

endpackage

// File: rtl/stream_demux_if.sv
// Upstream word/select plus per-lane downstream handshake bundle.
interface stream_demux_if
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_OUT = DEF_N_OUT,
  parameter int unsigned SEL_W = DEF_SEL_W
);

  logic [WIDTH-1:0]       in_data;
  logic [SEL_W-1:0]       in_sel;
  logic                   in_valid;
  logic                   in_ready;
  logic [N_OUT*WIDTH-1:0] out_data;
  logic [N_OUT-1:0]       out_valid;
  logic [N_OUT-1:0]       out_ready;

  // Environment side: producer drives the word, consumers drive ready.
  modport master (
    output in_data, in_sel, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  // Demultiplexer side.
  modport slave (
    input  in_data, in_sel, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );

endinterface

// File: rtl/stream_demux_sat_counter.sv
// Saturating up-counter; stops at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count increments until every bit is set, then holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demultiplexer with one holding stage.
// Optional macro STREAM_DEMUX_ROUND_ROBIN_EN: ignore in_sel and route to an
// internal lane pointer that advances per accepted word.
module stream_demux
  import stream_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_OUT = DEF_N_OUT,
  parameter int unsigned SEL_W = DEF_SEL_W,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  stream_demux_if.slave    bus,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  state_t                 state_q, state_d;
  logic [N_OUT-1:0]       valid_q, valid_d;
  logic [N_OUT*WIDTH-1:0] data_q, data_d;
  logic                   busy_d;
  logic                   load;
  logic                   drop_inc;
  logic                   hs;
  logic [SEL_W-1:0]       dest;
  logic                   dest_ok;

`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
  logic [SEL_W-1:0] ptr_q, ptr_d;

  assign dest    = ptr_q;
  assign dest_ok = 1'b1;

  // Pointer moves to the next lane (wrapping) on every accepted word.
  always_comb begin
    ptr_d = ptr_q;
    if (bus.in_valid && bus.in_ready) begin
      ptr_d = (ptr_q == SEL_W'(N_OUT - 1)) ? '0 : ptr_q + SEL_W'(1);
    end
  end

  // Lane pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`else
  assign dest    = bus.in_sel;
  assign dest_ok = lane_ok(32'(bus.in_sel), N_OUT);
`endif

  // Held word leaves when its own lane is ready; other lanes' ready is masked.
  assign hs           = (state_q == FULL) && (|(valid_q & bus.out_ready));
  assign bus.in_ready = (state_q == EMPTY) || hs;

  // Next state and next holding-register contents.
  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    data_d   = data_q;
    load     = 1'b0;
    drop_inc = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (bus.in_valid) begin
          if (dest_ok) load = 1'b1;
          else         drop_inc = 1'b1;
        end
      end
      FULL: begin
        if (hs) begin
          state_d = EMPTY;
          valid_d = '0;
          data_d  = '0;
          if (bus.in_valid) begin
            if (dest_ok) load = 1'b1;
            else         drop_inc = 1'b1;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      state_d = FULL;
      valid_d = '0;
      data_d  = '0;
      for (int unsigned k = 0; k < N_OUT; k++) begin
        if (dest == SEL_W'(k)) begin
          valid_d[k]               = 1'b1;
          data_d[k*WIDTH +: WIDTH] = bus.in_data;
        end
      end
    end
    busy_d = (state_d == FULL);
  end

  // State and holding registers; reset discards any held word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      valid_q <= '0;
      data_q  <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      busy    <= busy_d;
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

  sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (drop_inc),
    .count (drop_cnt)
  );

endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench: a 4-lane and a 3-lane demux against a transaction model.
module tb_stream_demux;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  // Per-DUT stimulus: index 0 = 4-lane, index 1 = 3-lane.
  logic       iv    [2];
  logic [1:0] isel  [2];
  logic [1:0] idata [2];
  logic [3:0] irdy  [2];

  logic [7:0] drop_a, drop_b;
  logic       busy_a, busy_b;

  stream_demux_if #(.WIDTH(2), .N_OUT(4), .SEL_W(2)) ifa ();
  stream_demux_if #(.WIDTH(2), .N_OUT(3), .SEL_W(2)) ifb ();

  assign ifa.in_valid  = iv[0];
  assign ifa.in_sel    = isel[0];
  assign ifa.in_data   = idata[0];
  assign ifa.out_ready = irdy[0];
  assign ifb.in_valid  = iv[1];
  assign ifb.in_sel    = isel[1];
  assign ifb.in_data   = idata[1];
  assign ifb.out_ready = irdy[1][2:0];

  stream_demux #(.WIDTH(2), .N_OUT(4), .SEL_W(2), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa), .drop_cnt(drop_a), .busy(busy_a)
  );

  stream_demux #(.WIDTH(2), .N_OUT(3), .SEL_W(2), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb), .drop_cnt(drop_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model: is a word held, where, what, plus drop tally.
  bit m_held [2];
  int m_lane [2];
  int m_data [2];
  int m_drop [2];
  int m_ptr  [2];
  int nout   [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_held[d] = 0; m_lane[d] = 0; m_data[d] = 0; m_drop[d] = 0; m_ptr[d] = 0;
    end
  endtask

  function automatic bit m_ready(input int d);
    return !m_held[d] || irdy[d][m_lane[d]];
  endfunction

  task automatic check_model(input int d);
    logic [31:0] er, ev, ed, eb, edr;
    logic [31:0] ar, av, ad, ab, adr;
    er  = 32'(m_ready(d));
    ev  = m_held[d] ? (32'd1 << m_lane[d]) : 32'd0;
    ed  = m_held[d] ? (32'(m_data[d]) << (2 * m_lane[d])) : 32'd0;
    eb  = 32'(m_held[d]);
    edr = 32'(m_drop[d]);
    if (d == 0) begin
      ar = 32'(ifa.in_ready); av = 32'(ifa.out_valid); ad = 32'(ifa.out_data);
      ab = 32'(busy_a); adr = 32'(drop_a);
    end else begin
      ar = 32'(ifb.in_ready); av = 32'(ifb.out_valid); ad = 32'(ifb.out_data);
      ab = 32'(busy_b); adr = 32'(drop_b);
    end
    chk($sformatf("dut%0d in_ready", d), ar, er);
    chk($sformatf("dut%0d out_valid", d), av, ev);
    chk($sformatf("dut%0d out_data", d), ad, ed);
    chk($sformatf("dut%0d busy", d), ab, eb);
    chk($sformatf("dut%0d drop_cnt", d), adr, edr);
  endtask

  task automatic m_update(input int d);
    bit rdy;
    rdy = m_ready(d);
    if (m_held[d] && rdy) m_held[d] = 0;
    if (iv[d] && rdy) begin
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
      m_held[d] = 1; m_lane[d] = m_ptr[d]; m_data[d] = int'(idata[d]);
      m_ptr[d] = (m_ptr[d] + 1) % nout[d];
`else
      if (int'(isel[d]) < nout[d]) begin
        m_held[d] = 1; m_lane[d] = int'(isel[d]); m_data[d] = int'(idata[d]);
      end else if (m_drop[d] < 255) begin
        m_drop[d]++;
      end
`endif
    end
  endtask

  // Compare both DUTs away from the active edge.
  task automatic sample();
    @(negedge clk);
    check_model(0);
    check_model(1);
  endtask

  // Let the model follow the coming edge, then step past it.
  task automatic advance();
    if (!rst_n) m_reset();
    else begin
      m_update(0);
      m_update(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int d, input logic v, input logic [1:0] s,
                        input logic [1:0] dat, input logic [3:0] r);
    iv[d] = v; isel[d] = s; idata[d] = dat; irdy[d] = r;
  endtask

  typedef struct {
    logic       v;
    logic [1:0] sel;
    logic [1:0] data;
    logic [3:0] rdy;
    logic       e_ready;
    logic [3:0] e_valid;
    logic [7:0] e_data;
    logic       e_busy;
  } vec_t;

  vec_t tbl [9];

  initial begin
    tests = 0;
    fails = 0;
    nout[0] = 4;
    nout[1] = 3;
    m_reset();
    set_in(0, 1'b0, 2'd0, 2'd0, 4'hF);
    set_in(1, 1'b0, 2'd0, 2'd0, 4'hF);
    rst_n = 1'b0;

    // Reset held for two cycles.
    for (int i = 0; i < 2; i++) begin
      sample();
      advance();
    end
    rst_n = 1'b1;

    // Directed table on the 4-lane unit, starting empty.
    tbl[0] = '{1'b1, 2'd1, 2'd2, 4'hF,    1'b1, 4'b0000, 8'h00, 1'b0};
    tbl[1] = '{1'b1, 2'd3, 2'd3, 4'hF,    1'b1, 4'b0010, 8'h08, 1'b1};
    tbl[2] = '{1'b1, 2'd0, 2'd1, 4'hF,    1'b1, 4'b1000, 8'hC0, 1'b1};
    tbl[3] = '{1'b0, 2'd0, 2'd0, 4'hF,    1'b1, 4'b0001, 8'h01, 1'b1};
    tbl[4] = '{1'b1, 2'd2, 2'd3, 4'b1011, 1'b1, 4'b0000, 8'h00, 1'b0};
    tbl[5] = '{1'b1, 2'd0, 2'd1, 4'b1011, 1'b0, 4'b0100, 8'h30, 1'b1};
    tbl[6] = '{1'b1, 2'd0, 2'd1, 4'b0100, 1'b1, 4'b0100, 8'h30, 1'b1};
    tbl[7] = '{1'b0, 2'd0, 2'd0, 4'hF,    1'b1, 4'b0001, 8'h01, 1'b1};
    tbl[8] = '{1'b0, 2'd0, 2'd0, 4'hF,    1'b1, 4'b0000, 8'h00, 1'b0};
`ifndef STREAM_DEMUX_ROUND_ROBIN_EN
    for (int i = 0; i < 9; i++) begin
      set_in(0, tbl[i].v, tbl[i].sel, tbl[i].data, tbl[i].rdy);
      sample();
      chk($sformatf("tbl%0d in_ready", i), 32'(ifa.in_ready), 32'(tbl[i].e_ready));
      chk($sformatf("tbl%0d out_valid", i), 32'(ifa.out_valid), 32'(tbl[i].e_valid));
      chk($sformatf("tbl%0d out_data", i), 32'(ifa.out_data), 32'(tbl[i].e_data));
      chk($sformatf("tbl%0d busy", i), 32'(busy_a), 32'(tbl[i].e_busy));
      advance();
    end
`endif

    // Exhaustive data x select sweep, back-to-back, all lanes ready.
    for (int d = 0; d < 4; d++) begin
      for (int s = 0; s < 4; s++) begin
        set_in(0, 1'b1, 2'(s), 2'(d), 4'hF);
        sample();
        chk("sweep in_ready", 32'(ifa.in_ready), 32'd1);
        advance();
      end
    end
    set_in(0, 1'b0, 2'd0, 2'd0, 4'hF);
    sample();
    advance();

    // Backpressure on lane 3 while other lanes are ready.
    set_in(0, 1'b1, 2'd3, 2'd3, 4'hF);
    sample();
    advance();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1'b1, 2'd0, 2'd1, 4'b0111);
      sample();
`ifndef STREAM_DEMUX_ROUND_ROBIN_EN
      chk("bp in_ready", 32'(ifa.in_ready), 32'd0);
      chk("bp out_valid", 32'(ifa.out_valid), 32'h8);
      chk("bp out_data", 32'(ifa.out_data), 32'hC0);
`endif
      advance();
    end
    set_in(0, 1'b1, 2'd0, 2'd1, 4'hF);
    sample();
    advance();
    set_in(0, 1'b0, 2'd0, 2'd0, 4'hF);
    sample();
    advance();

    // Randomized traffic on both units.
    for (int i = 0; i < 1500; i++) begin
      for (int d = 0; d < 2; d++) begin
        set_in(d, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom),
               ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF);
      end
      sample();
      advance();
    end
    set_in(0, 1'b0, 2'd0, 2'd0, 4'hF);
    set_in(1, 1'b0, 2'd0, 2'd0, 4'hF);
    sample();
    advance();

    // Out-of-range select on the 3-lane unit until the counter saturates.
    for (int i = 0; i < 300; i++) begin
      set_in(1, 1'b1, 2'd3, 2'($urandom), 4'hF);
      sample();
      advance();
    end
    set_in(1, 1'b0, 2'd0, 2'd0, 4'hF);
    sample();
`ifndef STREAM_DEMUX_ROUND_ROBIN_EN
    chk("drop saturated", 32'(drop_b), 32'd255);
    chk("drop no valid", 32'(ifb.out_valid), 32'd0);
`endif
    advance();

    // Asynchronous reset between edges while a word is held.
    set_in(0, 1'b1, 2'd2, 2'd1, 4'b0000);
    sample();
    advance();
    set_in(0, 1'b0, 2'd0, 2'd0, 4'b0000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async out_valid", 32'(ifa.out_valid), 32'd0);
    chk("async busy", 32'(busy_a), 32'd0);
    m_reset();
    sample();
    advance();
    rst_n = 1'b1;
    set_in(0, 1'b0, 2'd0, 2'd0, 4'hF);
    for (int i = 0; i < 2; i++) begin
      sample();
      chk("post reset no delivery", 32'(ifa.out_valid), 32'd0);
      advance();
    end

    // Six words in order; lanes must follow 0,1,2,3,0,1.
    for (int i = 0; i < 7; i++) begin
`ifdef STREAM_DEMUX_ROUND_ROBIN_EN
      set_in(0, (i < 6) ? 1'b1 : 1'b0, 2'd0, 2'(i), 4'hF);
`else
      set_in(0, (i < 6) ? 1'b1 : 1'b0, 2'(i % 4), 2'(i), 4'hF);
`endif
      sample();
      if (i > 0) begin
        chk($sformatf("seq%0d lane", i - 1), 32'(ifa.out_valid), 32'd1 << ((i - 1) % 4));
      end
      advance();
    end
    sample();
    chk("seq drop_cnt", 32'(drop_a), 32'd0);
    advance();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
